// File: rtl/foo_pack.sv
// foo_pack: packs a stream of 32-bit words into 64-bit {a,b} pairs.
// An odd-length burst closes with a zero-padded b half.
module foo_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] out_s,
  output logic        out_pad,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] pair_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] a_reg;
  logic [31:0] a_n;
  logic [63:0] s_n;
  logic        pad_n;
  logic        vld_n;
  logic [15:0] cnt_n;
  logic        take;
  logic        emit;

  // A word is taken whenever the output slot is free or drains now.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign take     = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  // State, held operand, output slot and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      out_s      <= '0;
      out_pad    <= 1'b0;
      out_valid  <= 1'b0;
      pair_count <= '0;
    end else begin
      state      <= state_n;
      a_reg      <= a_n;
      out_s      <= s_n;
      out_pad    <= pad_n;
      out_valid  <= vld_n;
      pair_count <= cnt_n;
    end
  end

  // Next state; a load in the same cycle as a drain keeps out_valid up.
  always_comb begin
    state_n = state;
    a_n     = a_reg;
    s_n     = out_s;
    pad_n   = out_pad;
    vld_n   = out_valid;
    cnt_n   = pair_count;
    if (emit) begin
      vld_n = 1'b0;
      cnt_n = pair_count + 16'd1;
    end
    if (take) begin
      unique case (state)
        IDLE: begin
          if (in_last) begin
            s_n   = {in_data, 32'h0};
            pad_n = 1'b1;
            vld_n = 1'b1;
          end else begin
            a_n     = in_data;
            state_n = HOLD;
          end
        end
        HOLD: begin
          s_n     = {a_reg, in_data};
          pad_n   = 1'b0;
          vld_n   = 1'b1;
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule
